// File: rtl/trace_item_packer.sv
// ---------------------------------------------------------------------------
// trace_item_packer
//
// Consumes the trace filter's keep/drop decision for every retired
// instruction. Dropped instructions only bump a saturating gap counter; kept
// instructions are packed into a trace item and queued in a
// first-word-fall-through FIFO. The downstream DMA/host path drains the FIFO
// over a valid/ready stream handshake.
//
// Item layout, MSB to LSB:
//    [timestamp (32b, optional)] lost | gap | pc | instr
//
// Optional feature macro: TRACE_ITEM_PACKER_TIMESTAMP_EN
//    When defined, a free-running 32-bit cycle counter is sampled into the top
//    32 bits of every item. When undefined, there is no counter and no field.
//
// Ports:
//    clk            single clock, rising edge
//    rst            synchronous active-high reset
//    en             enable for sampling; low freezes the gap counter
//    pc_valid       pc / instr / drop_instr are valid this cycle
//    pc             PC of the sampled instruction
//    instr          sampled instruction word
//    drop_instr     1 = discard (counted in gap), 0 = keep
//    m_tdata        head item of the FIFO
//    m_tvalid       FIFO not empty
//    m_tready       downstream accepts the head item
//    fifo_level     current FIFO occupancy
//    overflow_count kept items lost to a full FIFO, saturating
// ---------------------------------------------------------------------------
module trace_item_packer #(
   parameter int PC_WIDTH    = 64,
   parameter int INSTR_WIDTH = 32,
   parameter int GAP_WIDTH   = 16,
   parameter int FIFO_DEPTH  = 16,
`ifdef TRACE_ITEM_PACKER_TIMESTAMP_EN
   localparam int TS_WIDTH   = 32,
`else
   localparam int TS_WIDTH   = 0,
`endif
   localparam int ITEM_W     = TS_WIDTH + 1 + GAP_WIDTH + PC_WIDTH + INSTR_WIDTH,
   localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   pc_valid,
   input  logic [PC_WIDTH-1:0]    pc,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic                   drop_instr,
   output logic [ITEM_W-1:0]      m_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [LEVEL_W-1:0]     fifo_level,
   output logic [31:0]            overflow_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [ITEM_W-1:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [LEVEL_W-1:0]   level_q;
   logic [GAP_WIDTH-1:0] gap_q;
   logic [GAP_WIDTH-1:0] gap_d;
   logic                 lost_pending_q;
   logic [31:0]          overflow_q;
   logic [ITEM_W-1:0]    item;

   logic sample_ev;
   logic drop_ev;
   logic keep_ev;
   logic pop;
   logic full;
   logic space;
   logic push;
   logic lost_ev;

   // Event decode. A full FIFO still has room for a new item when the head is
   // leaving on the same edge, so push and pop can both happen at full level.
   always_comb begin
      sample_ev = en && pc_valid;
      drop_ev   = sample_ev && drop_instr;
      keep_ev   = sample_ev && !drop_instr;
      pop       = m_tvalid && m_tready;
      full      = (level_q == LEVEL_W'(FIFO_DEPTH));
      space     = !full || pop;
      push      = keep_ev && space;
      lost_ev   = keep_ev && !space;
   end

`ifdef TRACE_ITEM_PACKER_TIMESTAMP_EN
   logic [31:0] ts_q;

   // Free-running cycle counter; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + 32'd1;
      end
   end

   // Item assembly with the timestamp in the top bits.
   always_comb begin
      item = {ts_q, lost_pending_q, gap_q, pc, instr};
   end
`else
   // Item assembly without a timestamp field.
   always_comb begin
      item = {lost_pending_q, gap_q, pc, instr};
   end
`endif

   // Next gap value. A lost keep counts as a skipped instruction just like a
   // dropped one, so both saturate-increment; a successful push starts a new
   // gap from zero. With en low nothing here changes.
   always_comb begin
      gap_d = gap_q;
      if (drop_ev || lost_ev) begin
         if (gap_q != '1) begin
            gap_d = gap_q + GAP_WIDTH'(1);
         end
      end else if (push) begin
         gap_d = '0;
      end
   end

   // Storage array. It carries no reset: entries are only visible once the
   // level says they were written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= item;
      end
   end

   // Pointers, occupancy, gap/lost bookkeeping and the overflow counter.
   // Pointers wrap modulo the power-of-two depth; the separate level counter
   // is what tells full from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level_q        <= '0;
         gap_q          <= '0;
         lost_pending_q <= 1'b0;
         overflow_q     <= '0;
      end else begin
         gap_q <= gap_d;
         if (push) begin
            wr_ptr         <= wr_ptr + PTR_W'(1);
            lost_pending_q <= 1'b0;
         end else if (lost_ev) begin
            lost_pending_q <= 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            level_q <= level_q + LEVEL_W'(1);
         end else if (pop && !push) begin
            level_q <= level_q - LEVEL_W'(1);
         end
         if (lost_ev && (overflow_q != '1)) begin
            overflow_q <= overflow_q + 32'd1;
         end
      end
   end

   // First-word-fall-through read side: the head entry is always presented.
   always_comb begin
      m_tdata        = mem[rd_ptr];
      m_tvalid       = (level_q != '0);
      fifo_level     = level_q;
      overflow_count = overflow_q;
   end

endmodule

// File: tb/tb_trace_item_packer.sv
// ---------------------------------------------------------------------------
// tb_trace_item_packer
//
// Self-checking bench for trace_item_packer. Expected items are pushed onto a
// scoreboard queue when the keep is driven and compared against the head item
// whenever a handshake is seen. Occupancy and overflow counts are compared
// against constants from a vector table and from hand-written sequences.
// Optional feature macro: TRACE_ITEM_PACKER_TIMESTAMP_EN
// ---------------------------------------------------------------------------
module tb_trace_item_packer;

   localparam int PCW    = 64;
   localparam int IW     = 32;
   localparam int GW     = 16;
   localparam int DEPTH  = 16;
   localparam int LW     = $clog2(DEPTH) + 1;
   localparam int BASE_W = 1 + GW + PCW + IW;
`ifdef TRACE_ITEM_PACKER_TIMESTAMP_EN
   localparam int ITEM_W = BASE_W + 32;
`else
   localparam int ITEM_W = BASE_W;
`endif

   logic              clk;
   logic              rst;
   logic              en;
   logic              pc_valid;
   logic [PCW-1:0]    pc;
   logic [IW-1:0]     instr;
   logic              drop_instr;
   logic [ITEM_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic [LW-1:0]     fifo_level;
   logic [31:0]       overflow_count;

   int nChecks = 0;
   int nFails  = 0;

   logic [BASE_W-1:0] expQ[$];

   typedef struct {
      logic          en;
      logic          vld;
      logic          drop;
      logic          ready;
      logic [PCW-1:0] pc;
      logic          keepExp;
      logic [GW-1:0] expGap;
      logic          expLost;
      logic [LW-1:0] expLevel;
   } vec_t;

   vec_t vecs[11];

   trace_item_packer #(
      .PC_WIDTH   (PCW),
      .INSTR_WIDTH(IW),
      .GAP_WIDTH  (GW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .pc_valid      (pc_valid),
      .pc            (pc),
      .instr         (instr),
      .drop_instr    (drop_instr),
      .m_tdata       (m_tdata),
      .m_tvalid      (m_tvalid),
      .m_tready      (m_tready),
      .fifo_level    (fifo_level),
      .overflow_count(overflow_count)
   );

   // 10 time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction word derived from the PC so every item is distinguishable.
   function automatic logic [IW-1:0] instrOf(input logic [PCW-1:0] p);
      return {16'hC0DE, p[15:0]};
   endfunction

   function automatic vec_t mkVec(input logic e, input logic v, input logic d,
                                  input logic r, input logic [PCW-1:0] p,
                                  input logic k, input logic [GW-1:0] g,
                                  input logic l, input logic [LW-1:0] lvl);
      vec_t t;
      t.en = e; t.vld = v; t.drop = d; t.ready = r; t.pc = p;
      t.keepExp = k; t.expGap = g; t.expLost = l; t.expLevel = lvl;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of stimulus, queue the expected item if this is a keep
   // that should land in the FIFO, then step past the sampling edge.
   task automatic applyStimulus(input vec_t v);
      en         = v.en;
      pc_valid   = v.vld;
      drop_instr = v.drop;
      m_tready   = v.ready;
      pc         = v.pc;
      instr      = instrOf(v.pc);
      if (v.keepExp) begin
         expQ.push_back({v.expLost, v.expGap, v.pc, instrOf(v.pc)});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      en = 1'b0; pc_valid = 1'b0; drop_instr = 1'b0;
      pc = '0; instr = '0;
   endtask

   // Drain with ready high until both the DUT and the scoreboard are empty.
   task automatic drainAll(input int maxCycles);
      int n;
      n = 0;
      idleInputs();
      m_tready = 1'b1;
      while ((m_tvalid || expQ.size() != 0) && n < maxCycles) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);
      checkOutput("drain_level", 64'(fifo_level), 64'd0);
   endtask

   // Scoreboard monitor: mid-cycle, a visible handshake means the head item
   // leaves on the next edge, so compare it against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && m_tvalid && m_tready) begin
         nChecks++;
         if (expQ.size() == 0) begin
            nFails++;
            $display("[TB] FAIL unexpected_item: got 0x%0h, expected no item",
                     m_tdata[BASE_W-1:0]);
         end else begin
            logic [BASE_W-1:0] e;
            e = expQ.pop_front();
            if (m_tdata[BASE_W-1:0] !== e) begin
               nFails++;
               $display("[TB] FAIL item: got 0x%0h, expected 0x%0h",
                        m_tdata[BASE_W-1:0], e);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      m_tready = 1'b1;
      idleInputs();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("reset_level", 64'(fifo_level), 64'd0);
      checkOutput("reset_overflow", 64'(overflow_count), 64'd0);

      // Vector table: keep, three drops, keep; then en/pc_valid gating.
      //                   en    vld   drop  rdy   pc        keep  gap   lost  level
      vecs[0]  = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 64'h100, 1'b1, 16'd0, 1'b0, 5'd1);
      vecs[1]  = mkVec(1'b1, 1'b1, 1'b1, 1'b1, 64'h104, 1'b0, 16'd0, 1'b0, 5'd0);
      vecs[2]  = mkVec(1'b1, 1'b1, 1'b1, 1'b1, 64'h108, 1'b0, 16'd0, 1'b0, 5'd0);
      vecs[3]  = mkVec(1'b1, 1'b1, 1'b1, 1'b1, 64'h10C, 1'b0, 16'd0, 1'b0, 5'd0);
      vecs[4]  = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 64'h110, 1'b1, 16'd3, 1'b0, 5'd1);
      vecs[5]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 64'h114, 1'b0, 16'd0, 1'b0, 5'd0);
      vecs[6]  = mkVec(1'b1, 1'b1, 1'b1, 1'b1, 64'h118, 1'b0, 16'd0, 1'b0, 5'd0);
      vecs[7]  = mkVec(1'b0, 1'b1, 1'b0, 1'b1, 64'h11C, 1'b0, 16'd0, 1'b0, 5'd0);
      vecs[8]  = mkVec(1'b1, 1'b0, 1'b1, 1'b1, 64'h120, 1'b0, 16'd0, 1'b0, 5'd0);
      vecs[9]  = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 64'h124, 1'b1, 16'd1, 1'b0, 5'd1);
      vecs[10] = mkVec(1'b0, 1'b0, 1'b0, 1'b1, 64'h0,   1'b0, 16'd0, 1'b0, 5'd0);
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(vecs[i].expLevel));
      end
      drainAll(10);

      // Fill past full with ready low: 16 stored, 4 lost.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(mkVec(1'b1, 1'b1, 1'b0, 1'b0, 64'h1000 + 64'(4 * i),
                             (i < 16), 16'd0, 1'b0, 5'd0));
      end
      checkOutput("full_level", 64'(fifo_level), 64'd16);
      checkOutput("full_overflow", 64'(overflow_count), 64'd4);
      checkOutput("full_tvalid", 64'(m_tvalid), 64'd1);
      // Keep coinciding with a pop on a full FIFO is accepted and carries the
      // lost flag plus the four lost items in its gap.
      applyStimulus(mkVec(1'b1, 1'b1, 1'b0, 1'b1, 64'h2000, 1'b1, 16'd4, 1'b1, 5'd0));
      checkOutput("pushpop_level", 64'(fifo_level), 64'd16);
      checkOutput("pushpop_overflow", 64'(overflow_count), 64'd4);
      drainAll(40);

      // Gap saturation after 70000 drops, then a fresh gap of zero.
      en = 1'b1; pc_valid = 1'b1; drop_instr = 1'b1; m_tready = 1'b1;
      pc = 64'h3000; instr = instrOf(64'h3000);
      repeat (70000) @(posedge clk);
      #1;
      applyStimulus(mkVec(1'b1, 1'b1, 1'b0, 1'b1, 64'h4000, 1'b1, 16'hFFFF, 1'b0, 5'd0));
      applyStimulus(mkVec(1'b1, 1'b1, 1'b0, 1'b1, 64'h4004, 1'b1, 16'd0, 1'b0, 5'd0));
      drainAll(10);

      // Reset with items queued and a handshake pending flushes everything.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(mkVec(1'b1, 1'b1, 1'b0, 1'b0, 64'h5000 + 64'(4 * i),
                             1'b0, 16'd0, 1'b0, 5'd0));
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(mkVec(1'b1, 1'b1, 1'b1, 1'b0, 64'h5100, 1'b0, 16'd0, 1'b0, 5'd0));
      end
      checkOutput("prereset_level", 64'(fifo_level), 64'd5);
      idleInputs();
      m_tready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("flush_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("flush_level", 64'(fifo_level), 64'd0);
      checkOutput("flush_overflow", 64'(overflow_count), 64'd0);
      applyStimulus(mkVec(1'b1, 1'b1, 1'b0, 1'b1, 64'h6000, 1'b1, 16'd0, 1'b0, 5'd1));
      drainAll(10);

`ifdef TRACE_ITEM_PACKER_TIMESTAMP_EN
      // Timestamps of keeps at cycles 10 and 25 after reset.
      begin
         logic [31:0] tsA;
         logic [31:0] tsB;
         idleInputs();
         m_tready = 1'b0;
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         repeat (10) applyStimulus(mkVec(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 16'd0, 1'b0, 5'd0));
         applyStimulus(mkVec(1'b1, 1'b1, 1'b0, 1'b0, 64'h7000, 1'b1, 16'd0, 1'b0, 5'd1));
         repeat (14) applyStimulus(mkVec(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 16'd0, 1'b0, 5'd0));
         applyStimulus(mkVec(1'b1, 1'b1, 1'b0, 1'b0, 64'h7004, 1'b1, 16'd0, 1'b0, 5'd2));
         tsA = m_tdata[ITEM_W-1 -: 32];
         checkOutput("ts_first", 64'(tsA), 64'd10);
         applyStimulus(mkVec(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 1'b0, 16'd0, 1'b0, 5'd0));
         tsB = m_tdata[ITEM_W-1 -: 32];
         checkOutput("ts_second", 64'(tsB), 64'd25);
         checkOutput("ts_delta", 64'(tsB - tsA), 64'd15);
         drainAll(10);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
